// File: rtl/toy_pack.sv
// Shared types and default sizing for the multi-lane branch-target FIFO.
package toy_pack;

  localparam int BTFIFO_DEPTH     = 8;
  localparam int BTFIFO_ENQ_LANES = 2;

  typedef struct packed {
    logic [31:0] tgt;
    logic [7:0]  tag;
  } bpu_pkg;

endpackage

// File: rtl/toy_bpu_btfifo_compact.sv
// Lane filter and compactor: keeps valid lanes older than the first change-of-flow
// lane and packs them in program order into the low slots of pld_o.
module toy_bpu_btfifo_compact
  import toy_pack::*;
#(
  parameter  int ENQ_LANES = BTFIFO_ENQ_LANES,
  localparam int ACC_WIDTH = $clog2(ENQ_LANES + 1)
) (
  input  logic [ENQ_LANES-1:0]   vld_i,
  input  logic [ENQ_LANES-1:0]   chgflw_i,
  input  logic                   kill_i,
  input  bpu_pkg [ENQ_LANES-1:0] pld_i,
  output logic [ACC_WIDTH-1:0]   acc_cnt_o,
  output bpu_pkg [ENQ_LANES-1:0] pld_o
);

  logic [ENQ_LANES-1:0] acc;
  logic [ACC_WIDTH-1:0] pos [ENQ_LANES+1];

  // A lane survives only if no lane up to and including itself is a valid change-of-flow.
  for (genvar gi = 0; gi < ENQ_LANES; gi++) begin : g_acc
    assign acc[gi] = vld_i[gi] & ~kill_i & ~|(vld_i[gi:0] & chgflw_i[gi:0]);
  end

  always_comb begin
    pos[0] = '0;
    for (int i = 0; i < ENQ_LANES; i++) begin
      pos[i+1] = pos[i] + ACC_WIDTH'(acc[i]);
    end
    for (int k = 0; k < ENQ_LANES; k++) begin
      pld_o[k] = '0;
      for (int i = 0; i < ENQ_LANES; i++) begin
        if (acc[i] && pos[i] == ACC_WIDTH'(k)) pld_o[k] = pld_i[i];
      end
    end
    acc_cnt_o = pos[ENQ_LANES];
  end

endmodule

// File: rtl/toy_bpu_btfifo_mq.sv
// Multi-lane branch-target FIFO with registered head and registered ready.
// Optional perf counters are built only when TOY_BPU_BTFIFO_PERF_EN is defined.
module toy_bpu_btfifo_mq
  import toy_pack::*;
#(
  parameter  int DEPTH     = BTFIFO_DEPTH,
  parameter  int ENQ_LANES = BTFIFO_ENQ_LANES,
  localparam int PTR_WIDTH = $clog2(DEPTH),
  localparam int CNT_WIDTH = $clog2(DEPTH + 2)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ENQ_LANES-1:0]   bpdec_bp2_vld,
  input  logic [ENQ_LANES-1:0]   bpdec_bp2_chgflw,
  input  bpu_pkg [ENQ_LANES-1:0] bpdec_bp2_pld,
  output logic                   bpdec_rdy,
  input  logic                   filter_rdy,
  output logic                   filter_vld,
  output bpu_pkg                 filter_pld,
  input  logic                   fe_ctrl_flush,
  output logic [CNT_WIDTH-1:0]   occupancy,
  output logic                   ovf_err,
  output logic [CNT_WIDTH-1:0]   perf_hwm,
  output logic [31:0]            perf_stall_cnt
);

  localparam int SW        = PTR_WIDTH + 1;
  localparam int ACC_WIDTH = $clog2(ENQ_LANES + 1);

  logic [SW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  out_vld_q, out_vld_d, rdy_q, rdy_d, ovf_q, ovf_d;
  bpu_pkg                out_pld_q, out_pld_d;
  logic [CNT_WIDTH-1:0]  occ_q, occ_d;
  bpu_pkg                mem_q [DEPTH];

  logic [ACC_WIDTH-1:0]   acc_cnt;
  bpu_pkg [ENQ_LANES-1:0] cmp_pld, st_pld;
  logic [PTR_WIDTH-1:0]   wr_idx [ENQ_LANES];
  logic [SW-1:0]          stor_cnt;
  logic                   pop, load, from_stor, bypass;
  int                     to_store, free_slots, wr_cnt, next_stor;

  toy_bpu_btfifo_compact #(.ENQ_LANES(ENQ_LANES)) u_compact (
    .vld_i     (bpdec_bp2_vld),
    .chgflw_i  (bpdec_bp2_chgflw),
    .kill_i    (fe_ctrl_flush),
    .pld_i     (bpdec_bp2_pld),
    .acc_cnt_o (acc_cnt),
    .pld_o     (cmp_pld)
  );

  // When the oldest lane bypasses into the head register, storage sees the rest shifted down.
  for (genvar gi = 0; gi < ENQ_LANES; gi++) begin : g_store
    if (gi < ENQ_LANES - 1) begin : g_shift
      assign st_pld[gi] = bypass ? cmp_pld[gi+1] : cmp_pld[gi];
    end else begin : g_last
      assign st_pld[gi] = cmp_pld[gi];
    end
    assign wr_idx[gi] = wr_ptr_q[PTR_WIDTH-1:0] + PTR_WIDTH'(gi);
  end

  always_comb begin
    pop        = out_vld_q & filter_rdy;
    load       = ~out_vld_q | pop;
    stor_cnt   = wr_ptr_q - rd_ptr_q;
    from_stor  = load & (stor_cnt != '0);
    bypass     = load & (stor_cnt == '0) & (acc_cnt != '0);
    to_store   = int'(acc_cnt) - int'(bypass);
    free_slots = DEPTH - int'(stor_cnt) + int'(from_stor);
    wr_cnt     = (to_store > free_slots) ? free_slots : to_store;
    next_stor  = int'(stor_cnt) + wr_cnt - int'(from_stor);

    wr_ptr_d  = wr_ptr_q + SW'(wr_cnt);
    rd_ptr_d  = rd_ptr_q + SW'(from_stor);
    ovf_d     = ovf_q | (to_store > free_slots);
    out_vld_d = out_vld_q;
    out_pld_d = out_pld_q;
    if (load) begin
      if (from_stor) begin
        out_vld_d = 1'b1;
        out_pld_d = mem_q[rd_ptr_q[PTR_WIDTH-1:0]];
      end else if (bypass) begin
        out_vld_d = 1'b1;
        out_pld_d = cmp_pld[0];
      end else begin
        out_vld_d = 1'b0;
        out_pld_d = '0;
      end
    end
    rdy_d = (DEPTH - next_stor) >= ENQ_LANES;
    occ_d = CNT_WIDTH'(next_stor + int'(out_vld_d));

    if (fe_ctrl_flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      out_vld_d = 1'b0;
      out_pld_d = '0;
      rdy_d     = 1'b1;
      occ_d     = '0;
      ovf_d     = ovf_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      out_vld_q <= 1'b0;
      out_pld_q <= '0;
      rdy_q     <= 1'b1;
      ovf_q     <= 1'b0;
      occ_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      out_vld_q <= out_vld_d;
      out_pld_q <= out_pld_d;
      rdy_q     <= rdy_d;
      ovf_q     <= ovf_d;
      occ_q     <= occ_d;
    end
  end

  // wr_cnt is already zero during flush because the compactor kills every lane.
  always_ff @(posedge clk) begin
    for (int k = 0; k < ENQ_LANES; k++) begin
      if (k < wr_cnt) mem_q[wr_idx[k]] <= st_pld[k];
    end
  end

  assign bpdec_rdy  = rdy_q;
  assign filter_vld = out_vld_q;
  assign filter_pld = out_pld_q;
  assign occupancy  = occ_q;
  assign ovf_err    = ovf_q;

`ifdef TOY_BPU_BTFIFO_PERF_EN
  logic [CNT_WIDTH-1:0] hwm_q;
  logic [31:0]          stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm_q   <= '0;
      stall_q <= '0;
    end else begin
      if (occ_d > hwm_q) hwm_q <= occ_d;
      if (!rdy_q && stall_q != '1) stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_hwm       = hwm_q;
  assign perf_stall_cnt = stall_q;
`else
  assign perf_hwm       = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule
